mips_mem_responder: RTL



---
 rtl/mips_mem_pkg.sv | 26 ++
 rtl/mips_mem_array.sv | 46 ++++
 rtl/mips_mem_responder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and constants for the MIPS memory responder.
//   state_e   : responder FSM states (IDLE / WAIT / RESP)
//   ADDR_W_DEF, DATA_W_DEF : default word-address and data widths
//   WAIT_MAX  : largest supported WAIT_CYCLES value
//   CNT_W     : width of the latency down-counter
//   STAT_W    : width of the optional access statistics counters
//   sat_inc() : saturating increment for the statistics counters
package mips_mem_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int WAIT_MAX   = 15;
  localparam int CNT_W      = 4;
  localparam int STAT_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/mips_mem_array.sv
// mips_mem_array: single-port synchronous word storage, DEPTH x DATA_W.
//   clk1, rst_n : clock and async active-low reset (read register only)
//   en, we      : port enable; we=1 writes, we=0 reads into rdata
//   addr, wdata : word address (caller guarantees addr < DEPTH) and data
//   rdata       : registered read data, holds until the next read
// Storage contents are never reset.
module mips_mem_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic [IDX_W-1:0]  idx;

  assign idx = addr[IDX_W-1:0];

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem[idx];
  end

  always_ff @(posedge clk1) begin
    if (en && we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: memory-side responder for pipe_MIPS32 load/store traffic.
// Accepts one request at a time, waits WAIT_CYCLES, then returns load data or a
// store acknowledgement. A loader port preloads words while the responder idles.
//   clk1, rst_n              : clock, async active-low reset
//   req_valid/ready/we/addr/wdata : request channel
//   resp_valid/ready/rdata/err    : response channel (err: addr >= DEPTH)
//   ld_en/ready/addr/data    : loader write port (priority over requests)
//   rd_count, wr_count       : completed non-error loads/stores, saturating
//                              (present only with MIPS_MEM_STATS_EN defined)
//
// state | meaning
// IDLE  | accepting loader writes or one request
// WAIT  | latency countdown; access performed when counter reaches 0
// RESP  | response held until resp_ready
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  input  logic              ld_en,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
`ifdef MIPS_MEM_STATS_EN
  ,
  output logic [STAT_W-1:0] rd_count,
  output logic [STAT_W-1:0] wr_count
`endif
);

  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_L  = CNT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic              rd_sel_q, rd_sel_d;
`ifdef MIPS_MEM_STATS_EN
  logic [STAT_W-1:0] rd_count_q, rd_count_d;
  logic [STAT_W-1:0] wr_count_q, wr_count_d;
`endif

  logic              acc_fire, acc_we, acc_err, ld_fire;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              arr_en, arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata, arr_rdata;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    rd_sel_d     = rd_sel_q;
    acc_fire     = 1'b0;
    acc_we       = we_q;
    acc_addr     = addr_q;
    acc_wdata    = wdata_q;
    ld_fire      = 1'b0;

    case (state_q)
      IDLE: begin
        if (ld_en) begin
          ld_fire = ({1'b0, ld_addr} < DEPTH_L);
        end else if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            // Zero latency: access straight from the request bus.
            acc_fire  = 1'b1;
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            state_d   = RESP;
          end else begin
            cnt_d   = WAIT_L;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          acc_fire = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    acc_err = ({1'b0, acc_addr} >= DEPTH_L);
    if (acc_fire) begin
      resp_valid_d = 1'b1;
      resp_err_d   = acc_err;
      rd_sel_d     = !acc_we && !acc_err;
    end

    // Loader and core access are mutually exclusive: a request is only
    // accepted with ld_en low, and the loader is locked out outside IDLE.
    arr_en    = ld_fire || (acc_fire && !acc_err);
    arr_we    = ld_fire || acc_we;
    arr_addr  = ld_fire ? ld_addr : acc_addr;
    arr_wdata = ld_fire ? ld_data : acc_wdata;
  end

`ifdef MIPS_MEM_STATS_EN
  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (acc_fire && !acc_err) begin
      if (acc_we) wr_count_d = sat_inc(wr_count_q);
      else        rd_count_d = sat_inc(rd_count_q);
    end
  end
`endif

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rd_sel_q     <= 1'b0;
`ifdef MIPS_MEM_STATS_EN
      rd_count_q   <= '0;
      wr_count_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rd_sel_q     <= rd_sel_d;
`ifdef MIPS_MEM_STATS_EN
      rd_count_q   <= rd_count_d;
      wr_count_q   <= wr_count_d;
`endif
    end
  end

  mips_mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk1 (clk1),
    .rst_n(rst_n),
    .en   (arr_en),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  // Ready flags are gated by rst_n so they drop the moment reset asserts.
  assign req_ready  = rst_n && (state_q == IDLE) && !ld_en;
  assign ld_ready   = rst_n && (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  // Read register holds between accesses; only loads expose it.
  assign resp_rdata = rd_sel_q ? arr_rdata : '0;
`ifdef MIPS_MEM_STATS_EN
  assign rd_count   = rd_count_q;
  assign wr_count   = wr_count_q;
`endif

endmodule
